// File: rtl/sym_ib_lut_pkg.sv
// sym_ib_lut_pkg: shared sizes and loader state encoding for the symmetric VN IB-LUT.
package sym_ib_lut_pkg;
    localparam int PAGE_NUM    = 64;
    localparam int PAGE_ADDR_W = $clog2(PAGE_NUM);
    localparam int LUT_DATA_W  = 4;
    localparam int WORD_W      = 2 * LUT_DATA_W;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_e;
endpackage

// File: rtl/sym_vn_lut_loader_if.sv
// sym_vn_lut_loader_if: LUT page stream in, RAM write port out.
interface sym_vn_lut_loader_if;
    import sym_ib_lut_pkg::*;
    logic [WORD_W-1:0]      lut_word_in;
    logic                   lut_valid;
    logic                   lut_ready;
    logic [LUT_DATA_W-1:0]  lut_in_bank0;
    logic [LUT_DATA_W-1:0]  lut_in_bank1;
    logic [PAGE_ADDR_W-1:0] page_write_addr;
    logic                   write_addr_offset;
    logic                   we;
    modport master (
        output lut_word_in, lut_valid,
        input  lut_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
    );
    modport slave (
        input  lut_word_in, lut_valid,
        output lut_ready, lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we
    );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// sym_vn_lut_loader: ping-pong write feeder for the VN IB-LUT RAM; fills the idle offset half
// and optionally hands it to the reader on completion.
module sym_vn_lut_loader
    import sym_ib_lut_pkg::*;
(
    input  logic               write_clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               swap_en,
    input  logic               load_abort,
    sym_vn_lut_loader_if.slave bus,
    output logic               read_addr_offset,
    output logic               load_busy,
    output logic               load_done
);
    ld_state_e state_q, state_d;
    logic [PAGE_ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d;
    logic [LUT_DATA_W-1:0]  b0_q, b0_d, b1_q, b1_d;
    logic tgt_q, tgt_d, swap_q, swap_d, woff_q, woff_d, we_q, we_d;
    logic roff_q, roff_d, busy_q, busy_d, done_q, done_d;
    logic accept, start;

    always_comb begin
        accept  = (state_q == LOAD) && !load_abort && bus.lut_valid;
        start   = (state_q == IDLE) && load_start;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load_start ? LOAD : IDLE;
            LOAD:    state_d = load_abort ? IDLE :
                               (accept && cnt_q == PAGE_ADDR_W'(PAGE_NUM - 1)) ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
        cnt_d  = start ? '0 : accept ? cnt_q + PAGE_ADDR_W'(1) : cnt_q;
        tgt_d  = start ? ~roff_q : tgt_q;
        swap_d = start ? swap_en : swap_q;
        we_d   = accept;
        addr_d = accept ? cnt_q : addr_q;
        b0_d   = accept ? bus.lut_word_in[LUT_DATA_W-1:0] : b0_q;
        b1_d   = accept ? bus.lut_word_in[WORD_W-1:LUT_DATA_W] : b1_q;
        woff_d = accept ? tgt_q : woff_q;
        // The read half flips only on the cycle after the final write has landed.
        roff_d = (state_q == DONE && swap_q) ? tgt_q : roff_q;
        done_d = state_q == DONE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            swap_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            woff_q  <= 1'b0;
            roff_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            swap_q  <= swap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            woff_q  <= woff_d;
            roff_q  <= roff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.lut_ready         = (state_q == LOAD) && !load_abort;
    assign bus.lut_in_bank0      = b0_q;
    assign bus.lut_in_bank1      = b1_q;
    assign bus.page_write_addr   = addr_q;
    assign bus.write_addr_offset = woff_q;
    assign bus.we                = we_q;
    assign read_addr_offset      = roff_q;
    assign load_busy             = busy_q;
    assign load_done             = done_q;
endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// tb_sym_vn_lut_loader: cycle-level reference model of the loader driven by directed and random
// page streams; every output is compared each cycle.
module tb_sym_vn_lut_loader;
    import sym_ib_lut_pkg::*;
    logic write_clk = 1'b0, rst = 1'b1, load_start = 1'b0, swap_en = 1'b0, load_abort = 1'b0;
    logic read_addr_offset, load_busy, load_done;
    int n_checks = 0, n_fail = 0;
    sym_vn_lut_loader_if bus();

    sym_vn_lut_loader dut (
        .write_clk(write_clk), .rst(rst), .load_start(load_start), .swap_en(swap_en),
        .load_abort(load_abort), .bus(bus.slave), .read_addr_offset(read_addr_offset),
        .load_busy(load_busy), .load_done(load_done)
    );

    always #5 write_clk = ~write_clk;

    // Model: a load is "in flight" while pages remain; the handover cycle follows the last page.
    bit m_load, m_fin, m_tgt, m_swap, m_roff;
    int m_page;
    logic e_we, e_off, e_done;
    logic [5:0] e_addr;
    logic [3:0] e_b0, e_b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_fin = 0; m_tgt = 0; m_swap = 0; m_roff = 0; m_page = 0;
        e_we = 0; e_off = 0; e_done = 0; e_addr = 0; e_b0 = 0; e_b1 = 0;
    endtask

    task automatic check_outputs();
        check_eq("we", bus.we, e_we);
        check_eq("addr", bus.page_write_addr, e_addr);
        check_eq("bank0", bus.lut_in_bank0, e_b0);
        check_eq("bank1", bus.lut_in_bank1, e_b1);
        check_eq("wr_off", bus.write_addr_offset, e_off);
        check_eq("rd_off", read_addr_offset, m_roff);
        check_eq("busy", load_busy, m_load || m_fin);
        check_eq("done", load_done, e_done);
    endtask

    task automatic cyc(input logic st, input logic sw, input logic ab, input logic v,
                       input logic [7:0] w);
        bit idle, acc;
        @(negedge write_clk);
        load_start = st; swap_en = sw; load_abort = ab; bus.lut_valid = v; bus.lut_word_in = w;
        #1;
        check_eq("ready", bus.lut_ready, m_load && !ab);
        idle = !m_load && !m_fin;
        acc = m_load && !ab && v;
        e_done = m_fin;
        if (m_fin && m_swap) m_roff = m_tgt;
        m_fin = 0;
        e_we = acc;
        if (acc) begin
            e_addr = 6'(m_page); e_b0 = w[3:0]; e_b1 = w[7:4]; e_off = m_tgt;
            m_page++;
            if (m_page == PAGE_NUM) begin m_load = 0; m_fin = 1; end
        end
        if (m_load && ab) m_load = 0;
        if (idle && st) begin m_load = 1; m_page = 0; m_tgt = !m_roff; m_swap = sw; end
        @(posedge write_clk);
        #1;
        check_outputs();
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps and data
    task automatic run_load(input logic sw, input int mode, input int abort_at, input int start_at);
        logic v;
        cyc(1, sw, 0, 0, 8'h00);
        for (int n = 0; n < 400 && m_load; n++) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? n[0] : ($urandom_range(0, 3) != 0);
            cyc(m_page == start_at, $urandom_range(0, 1) == 1, m_page == abort_at && v, v,
                mode == 2 ? 8'($urandom) : 8'(m_page));
        end
        if (m_load) check_eq("load_timeout", 1, 0);
        repeat (3) cyc(0, 0, 0, $urandom_range(0, 1) == 1, 8'($urandom));
    endtask

    initial begin
        bus.lut_valid = 0; bus.lut_word_in = 0;
        model_reset();
        #12;
        check_outputs();
        check_eq("ready_rst", bus.lut_ready, 0);
        @(negedge write_clk) rst = 0;
        run_load(1, 0, -1, -1);
        run_load(1, 1, -1, -1);
        run_load(1, 0, -1, -1);
        run_load(0, 0, -1, -1);
        run_load(1, 0, 20, -1);
        cyc(0, 0, 1, 1, 8'h5a);
        run_load(1, 0, -1, -1);
        run_load(0, 2, -1, 10);
        for (int r = 0; r < 4; r++)
            run_load($urandom_range(0, 1) == 1, 2, $urandom_range(0, 7) == 0 ? 33 : -1, 5);
        cyc(1, 1, 0, 0, 8'h00);
        while (m_page < 30) cyc(0, 0, 0, 1, 8'(m_page));
        #2 rst = 1;
        #1;
        model_reset();
        check_outputs();
        check_eq("ready_midrst", bus.lut_ready, 0);
        @(negedge write_clk);
        #2 rst = 0;
        repeat (3) cyc(0, 0, 0, 1, 8'hc3);
        run_load(1, 2, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
